// File: rtl/t01_button_conditioner.sv
// Per-channel button conditioner: synchronizer, debounce, press/release pulses and auto-repeat.
// Auto-repeat logic is compiled in only when T01_BTN_AUTOREPEAT_EN is defined.
module t01_button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (NUM_BTN < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("t01_button_conditioner: parameter out of range");
  end

`ifdef T01_BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DB_W-1:0]        db_cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   toggle;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        // NOTE: non-blocking so each stage captures the previous stage's old value.
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
      end
    end

    assign sync   = sync_q[SYNC_STAGES-1];
    assign toggle = (sync != level_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));

    // The pulses are registered on the same edge the level flips, so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= toggle & ~level_q;
        release_q <= toggle & level_q;
        if (toggle) begin
          level_q  <= ~level_q;
          db_cnt_q <= '0;
        end else if (sync != level_q) begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end else begin
          db_cnt_q <= '0;
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef T01_BTN_AUTOREPEAT_EN
    logic             rise;
    logic             fall;
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_q, rpt_d;

    assign rise = toggle & ~level_q;
    assign fall = toggle & level_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= RPT_IDLE;
        rpt_cnt_q <= '0;
        rpt_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
        rpt_q     <= rpt_d;
      end
    end

    // rpt_cnt counts cycles since the press (DELAY) or since the last repeat pulse (REPEAT).
    always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_d     = 1'b0;
      if (fall) begin
        state_d   = RPT_IDLE;
        rpt_cnt_d = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            if (rise) begin
              state_d   = RPT_DELAY;
              rpt_cnt_d = '0;
            end
          end
          RPT_DELAY: begin
            if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
              state_d   = RPT_REPEAT;
              rpt_cnt_d = '0;
              rpt_d     = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
              rpt_cnt_d = '0;
              rpt_d     = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
          end
          default: begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end

    assign btn_repeat[i] = rpt_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_t01_button_conditioner.sv
// Self-checking bench for t01_button_conditioner: directed scenarios plus random stimulus,
// all compared every cycle against a timeline-based reference model.
module tb_t01_button_conditioner;

  localparam int N  = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  t01_button_conditioner #(
    .NUM_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: the debounce input at edge n is the btn_in sampled SS edges earlier;
  // the level flips after DB consecutive disagreeing edges; repeats follow from the press time.
  int           edge_n = 0;
  bit           hist [N][SS];
  int           run  [N];
  bit           lvl  [N];
  int           pcyc [N];
  bit [N-1:0]   e_lvl, e_prs, e_rel, e_rpt;

  // Observed event times, used by the directed scenarios.
  int           lp [N];
  int           rpt_off [$];

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      for (int j = 0; j < SS; j++) hist[c][j] = 1'b0;
      run[c]  = 0;
      lvl[c]  = 1'b0;
      pcyc[c] = 0;
    end
    e_lvl = '0; e_prs = '0; e_rel = '0; e_rpt = '0;
  endfunction

  function automatic void model_edge();
    bit d;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      d = hist[c][SS-1];
      for (int j = SS - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = btn_in[c];
      e_prs[c] = 1'b0;
      e_rel[c] = 1'b0;
      if (d != lvl[c]) begin
        run[c]++;
        if (run[c] == DB) begin
          lvl[c] = ~lvl[c];
          run[c] = 0;
          if (lvl[c]) begin
            e_prs[c] = 1'b1;
            pcyc[c]  = edge_n;
          end else begin
            e_rel[c] = 1'b1;
          end
        end
      end else begin
        run[c] = 0;
      end
      e_lvl[c] = lvl[c];
`ifdef T01_BTN_AUTOREPEAT_EN
      e_rpt[c] = lvl[c] && !e_prs[c] && (edge_n - pcyc[c] >= RD) &&
                 ((edge_n - pcyc[c] - RD) % RP == 0);
`else
      e_rpt[c] = 1'b0;
`endif
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check($sformatf("level@%0d", edge_n),   32'(btn_level),   32'(e_lvl));
    check($sformatf("press@%0d", edge_n),   32'(btn_press),   32'(e_prs));
    check($sformatf("release@%0d", edge_n), 32'(btn_release), 32'(e_rel));
    check($sformatf("repeat@%0d", edge_n),  32'(btn_repeat),  32'(e_rpt));
    for (int c = 0; c < N; c++) if (btn_press[c]) lp[c] = edge_n;
    if (btn_repeat[1]) rpt_off.push_back(edge_n - lp[1]);
  endtask

  task automatic idle(input int cycles);
    btn_in = '0;
    repeat (cycles) cycle();
  endtask

  task automatic wait_press(input int ch, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (btn_press[ch]) seen = 1'b1;
    end
  endtask

  initial begin
    int k, p, r;
    bit seen;
    bit [N-1:0] any_pulse;

    model_reset();
    for (int c = 0; c < N; c++) lp[c] = 0;
    #1;
    check("reset_level",   32'(btn_level),   0);
    check("reset_press",   32'(btn_press),   0);
    check("reset_release", 32'(btn_release), 0);
    check("reset_repeat",  32'(btn_repeat),  0);
    repeat (3) cycle();
    rst_n = 1'b1;
    idle(4);

    // Press latency on channel 0.
    btn_in[0] = 1'b1;
    k = edge_n + 1;
    repeat (5) cycle();
    check("lat_press_before_k5", 32'(btn_press[0]), 0);
    cycle();
    check("lat_k5_edge", 32'(edge_n - k), 5);
    check("lat_level_k5", 32'(btn_level[0]), 1);
    check("lat_press_k5", 32'(btn_press[0]), 1);
    cycle();
    check("lat_press_k6", 32'(btn_press[0]), 0);
    repeat (40) cycle();
    btn_in[0] = 1'b0;
    idle(12);

    // Three-cycle glitch must be ignored.
    any_pulse = '0;
    btn_in[0] = 1'b1;
    repeat (3) begin
      cycle();
      any_pulse |= btn_level | btn_press | btn_release;
    end
    btn_in[0] = 1'b0;
    repeat (15) begin
      cycle();
      any_pulse |= btn_level | btn_press | btn_release;
    end
    check("glitch_no_effect", 32'(any_pulse), 0);

    // Repeat cadence on channel 1, then release.
    rpt_off.delete();
    btn_in[1] = 1'b1;
    wait_press(1, 20, seen);
    check("c_press_seen", 32'(seen), 1);
    p = edge_n;
    repeat (11) cycle();
    btn_in[1] = 1'b0;
    repeat (12) cycle();
`ifdef T01_BTN_AUTOREPEAT_EN
    check("c_rpt_count", rpt_off.size(), 3);
    if (rpt_off.size() == 3) begin
      check("c_rpt_0", rpt_off[0], 10);
      check("c_rpt_1", rpt_off[1], 13);
      check("c_rpt_2", rpt_off[2], 16);
    end
`else
    check("c_rpt_count", rpt_off.size(), 0);
`endif
    check("c_press_time", 32'(lp[1]), 32'(p));
    idle(6);

    // Simultaneous press on both channels; release channel 0 only.
    rpt_off.delete();
    btn_in = 2'b11;
    k = edge_n + 1;
    wait_press(1, 20, seen);
    check("d_press_seen", 32'(seen), 1);
    check("d_press0_lat", 32'(lp[0] - k), 5);
    check("d_press1_lat", 32'(lp[1] - k), 5);
    repeat (4) cycle();
    btn_in = 2'b10;
    repeat (20) cycle();
`ifdef T01_BTN_AUTOREPEAT_EN
    check("d_rpt1_count", rpt_off.size(), 5);
`else
    check("d_rpt1_count", rpt_off.size(), 0);
`endif
    idle(12);

    // Reset in the middle of the repeat phase.
    btn_in[1] = 1'b1;
    wait_press(1, 20, seen);
    check("e_press_seen", 32'(seen), 1);
    repeat (12) cycle();
    rst_n = 1'b0;
    #1;
    check("e_rst_level",   32'(btn_level),   0);
    check("e_rst_press",   32'(btn_press),   0);
    check("e_rst_release", 32'(btn_release), 0);
    check("e_rst_repeat",  32'(btn_repeat),  0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    r = edge_n + 1;
    wait_press(1, 20, seen);
    check("e_repress_seen", 32'(seen), 1);
    check("e_repress_lat", 32'(lp[1] - r), 5);
    repeat (15) cycle();
    idle(12);

    // Random stimulus with long holds, glitches and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 7) == 0) btn_in[c] = ~btn_in[c];
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rand_rst_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/t01_button_conditioner.md
T01_BUTTON_CONDITIONER -- requirements
Module: t01_button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of independent button channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth per channel (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a new level (>=1).
REQ-004 SHALL have parameter REPEAT_DELAY, default 8: cycles from press pulse to first repeat pulse (>=1).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 4: cycles between later repeat pulses (>=1).
REQ-006 SHALL have port clk, input, 1: sole clock; all state on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port btn_in, input, NUM_BTN: raw asynchronous button inputs, active-high.
REQ-009 SHALL have port btn_level, output, NUM_BTN: debounced, synchronized button level.
REQ-010 SHALL have port btn_press, output, NUM_BTN: one-cycle pulse on debounced rising edge.
REQ-011 SHALL have port btn_release, output, NUM_BTN: one-cycle pulse on debounced falling edge.
REQ-012 SHALL have port btn_repeat, output, NUM_BTN: one-cycle auto-repeat pulses while held.

Function
REQ-013 Each channel SHALL pass btn_in[i] through SYNC_STAGES flops; only the last stage's value (sync[i]) feeds later logic.
REQ-014 Per channel, a counter of width $clog2(DEBOUNCE_CYCLES+1) SHALL increment on each edge where sync[i] != btn_level[i] and clear to 0 on any edge where they are equal.
REQ-015 btn_level[i] SHALL toggle, and the counter clear, on the DEBOUNCE_CYCLES-th consecutive edge with sync[i] != btn_level[i]; total latency from first edge sampling a new btn_in value is SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-016 An input disturbance lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL not change btn_level and SHALL produce no pulses.
REQ-017 btn_press[i] (btn_release[i]) SHALL be registered high for exactly the one cycle in which btn_level[i] first reads 1 (0), and low otherwise.
REQ-018 Auto-repeat SHALL use a per-channel FSM IDLE -> DELAY -> REPEAT with a cycle counter: IDLE->DELAY on press; DELAY->REPEAT after REPEAT_DELAY cycles, pulsing btn_repeat; in REPEAT, pulse every REPEAT_PERIOD cycles.
REQ-019 With press pulse in cycle p, btn_repeat[i] SHALL be high in cycles p+REPEAT_DELAY+n*REPEAT_PERIOD, n>=0, while btn_level[i] stays 1.
REQ-020 Any state SHALL return to IDLE and clear its counter on the edge btn_level[i] falls; btn_repeat[i] SHALL never be high in the btn_release[i] cycle.
REQ-021 Channels SHALL be fully independent; simultaneous events on different channels SHALL each behave as if alone.
REQ-022 Repeat counters SHALL not wrap: holding indefinitely yields pulses at exactly REPEAT_PERIOD spacing forever.

Reset
REQ-023 While rst_n=0, all synchronizer flops, debounce counters, repeat counters and btn_level SHALL be 0, all FSMs IDLE, and btn_press/btn_release/btn_repeat 0.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abort immediately with no pulse emitted; after deassertion a held button SHALL be re-debounced and yield a fresh btn_press.

Configuration
REQ-025 Macro T01_BTN_AUTOREPEAT_EN defined: auto-repeat FSM and counters (REQ-018..REQ-020, REQ-022) SHALL be compiled in.
REQ-026 Macro T01_BTN_AUTOREPEAT_EN undefined: no repeat logic SHALL be instantiated and btn_repeat SHALL be constant 0; all other behaviour unchanged.

Verification (NUM_BTN=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, macro defined unless stated)
REQ-027 btn_in[0] 0->1 sampled at edge k, held -> btn_level[0]=1 and btn_press[0]=1 after edge k+5, btn_press[0]=0 after k+6.
REQ-028 btn_in[0] high for 3 cycles then low -> btn_level, btn_press, btn_release remain 0 throughout.
REQ-029 Hold btn_in[1], press pulse cycle p -> btn_repeat[1] high exactly in p+10, p+13, p+16; release -> btn_release[1] one cycle, no further repeat.
REQ-030 Both channels pressed at same edge -> identical press timing on both; release channel 0 only -> channel 1 repeat cadence unchanged.
REQ-031 rst_n low 1 cycle at p+12 while btn_in[1] held -> all outputs 0 immediately; new btn_press[1] 6 edges after release of reset; no repeat before its p'+10.
REQ-032 Macro undefined, hold btn_in[0] 40 cycles -> btn_repeat stays 0; press/release timing as REQ-027.
